// File: rtl/fetch_controller.sv
// fetch_controller
//   Sequencing controller for the instruction-fetch stage of the 16-bit
//   pipelined RISC core. It drives the PC select mux and the PC write enable,
//   handshakes with instruction memory, applies load-use stalls and
//   taken-branch redirects, and controls the IF/ID pipeline register. It also
//   counts stall and flush events for debug.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous active-low reset
//   load_use_hazard  decode requests a one-cycle fetch stall
//   branch_taken     execute resolved a taken branch/jump (single-cycle pulse)
//   branch_target    redirect address, valid with branch_taken
//   halt             halt instruction decoded
//   imem_ready       instruction memory returns data for the current request
//   imem_req         fetch request to instruction memory (address = PC)
//   pc_write         PC register enable
//   pc_mux_control   0 = PC+2 adder, 1 = pc_target
//   pc_target        redirect address into the PC mux second input
//   if_id_write      IF/ID register load enable
//   if_id_flush      IF/ID register clear (inserts a bubble)
//   halted           controller is in HALTED
//   stall_count      saturating count of stall cycles
//   flush_count      saturating count of flushes
module fetch_controller #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_use_hazard,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic              pc_write,
    output logic              pc_mux_control,
    output logic [ADDR_W-1:0] pc_target,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_HALTED
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        boot_cnt;
    logic              redirect_pending;
    logic              halt_pending;
    logic [ADDR_W-1:0] target_q;

    logic              capture_target;
    logic              redirect_now;
    logic              stall_evt;
    logic              flush_evt;

    always_comb begin
        state_next     = state;
        imem_req       = 1'b0;
        pc_write       = 1'b0;
        pc_mux_control = 1'b0;
        if_id_write    = 1'b0;
        if_id_flush    = 1'b0;
        halted         = 1'b0;
        capture_target = 1'b0;
        redirect_now   = 1'b0;
        stall_evt      = 1'b0;
        flush_evt      = 1'b0;

        case (state)
            S_BOOT: begin
                if (boot_cnt == 8'(BOOT_CYCLES - 1)) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                if (branch_taken) begin
                    if_id_flush    = 1'b1;
                    pc_mux_control = 1'b1;
                    pc_write       = 1'b1;
                    capture_target = 1'b1;
                    flush_evt      = 1'b1;
                end else if (halt) begin
                    state_next = S_HALTED;
                end else if (load_use_hazard) begin
                    stall_evt = 1'b1;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // The outstanding request stays asserted whatever else happens.
                imem_req = 1'b1;
                // Only the first branch seen while waiting is captured.
                capture_target = branch_taken & ~redirect_pending;
                redirect_now   = redirect_pending | branch_taken;
                if (imem_ready) begin
                    if (redirect_now) begin
                        // Redirect wins over a recorded halt and over a stall.
                        if_id_flush    = 1'b1;
                        pc_mux_control = 1'b1;
                        pc_write       = 1'b1;
                        flush_evt      = 1'b1;
                        state_next     = S_FETCH;
                    end else begin
                        if (load_use_hazard) begin
                            // Returned word is dropped; PC unchanged, so it is refetched.
                            stall_evt = 1'b1;
                        end else begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                        end
                        state_next = (halt_pending | halt) ? S_HALTED : S_FETCH;
                    end
                end
            end

            S_HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    assign pc_target = capture_target ? branch_target : target_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_BOOT;
            boot_cnt         <= '0;
            redirect_pending <= 1'b0;
            halt_pending     <= 1'b0;
            target_q         <= '0;
            stall_count      <= '0;
            flush_count      <= '0;
        end else begin
            state <= state_next;

            if (state == S_BOOT) begin
                boot_cnt <= boot_cnt + 8'd1;
            end

            if (capture_target) begin
                target_q <= branch_target;
            end

            if (state == S_WAIT) begin
                if (imem_ready) begin
                    redirect_pending <= 1'b0;
                    halt_pending     <= 1'b0;
                end else begin
                    if (branch_taken) redirect_pending <= 1'b1;
                    if (halt)         halt_pending     <= 1'b1;
                end
            end

            if (stall_evt && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush_evt && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequencing controller for the instruction-fetch stage of the 16-bit pipelined RISC processor.
- Drives the PC select mux and PC write enable.
- Handshakes with instruction memory.
- Applies load-use stalls and taken-branch redirects from decode/execute.
- Controls the IF/ID pipeline register (write/flush).

It supplies the redirect target into the PC mux's second input and counts stall/flush events for debug.

Parameters:
ADDR_W, 16, PC/target width
BOOT_CYCLES, 4, cycles held idle after reset release before the first fetch (1..255)
CNT_W, 8, width of the saturating event counters

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
load_use_hazard  input  1  decode requests a one-cycle fetch stall
branch_taken  input  1  execute resolved a taken branch/jump this cycle (single-cycle pulse)
branch_target  input  ADDR_W  target address, valid with branch_taken
halt  input  1  halt instruction decoded
imem_ready  input  1  instruction memory returns data for the current request this cycle
imem_req  output  1  fetch request to instruction memory (address = current PC)
pc_write  output  1  PC register enable (PCWrite)
pc_mux_control  output  1  0 = PC+2 adder, 1 = pc_target
pc_target  output  ADDR_W  latched redirect address into PC mux in_2
if_id_write  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID register clear (inserts bubble)
halted  output  1  controller is in HALTED
stall_count  output  CNT_W  saturating count of stall cycles
flush_count  output  CNT_W  saturating count of flushes

Behaviour:
- Reset (reset=0, asynchronous):
  - State BOOT; boot counter 0; redirect_pending 0.
  - pc_target 0; both counters 0; all 1-bit outputs 0.
- States: BOOT, FETCH, WAIT, HALTED. Outputs are combinational from state and inputs; pc_target and counters are registered.
- BOOT:
  - All enables 0.
  - Counter increments each cycle; on reaching BOOT_CYCLES-1, goes to FETCH.
  - branch_taken and halt are ignored.
- FETCH, priority branch_taken > halt > load_use_hazard > normal:
  - branch_taken:
    - Drive if_id_flush=1, pc_mux_control=1, pc_write=1, imem_req=0.
    - pc_target is combinationally branch_target this cycle and is registered for later cycles.
    - flush_count++; stay in FETCH.
  - halt: imem_req=0, pc_write=0, if_id_write=0; next state HALTED.
  - load_use_hazard: imem_req=0, pc_write=0, if_id_write=0; stall_count++; stay in FETCH.
  - Normal: imem_req=1.
    - If imem_ready: pc_write=1, pc_mux_control=0, if_id_write=1; stay in FETCH (throughput 1 instr/cycle).
    - If not imem_ready: next state WAIT.
- WAIT (an issued request can never be withdrawn):
  - imem_req held 1; pc_write=0, if_id_write=0 until imem_ready.
  - branch_taken in WAIT: latch branch_target into pc_target and set redirect_pending=1; branch_taken is not re-sampled.
  - On imem_ready with redirect_pending=1 (including a branch arriving in the same cycle as imem_ready):
    - Drive if_id_flush=1, if_id_write=0, pc_mux_control=1, pc_write=1.
    - Clear redirect_pending; flush_count++; next state FETCH.
  - On imem_ready, no redirect:
    - pc_write=1, pc_mux_control=0, if_id_write=1; next state FETCH.
  - load_use_hazard in WAIT: the completing write is suppressed (pc_write=0, if_id_write=0). The returned data is dropped and refetched next cycle; stall_count++.
  - halt in WAIT: recorded; taken on the completion cycle (completion writes occur, then HALTED). A pending redirect takes precedence and discards the halt.
- HALTED:
  - halted=1; all enables 0; imem_req 0.
  - All inputs ignored; exit only via reset.
- Counters saturate at 2^CNT_W-1; no wrap.
- Reset asserted mid-WAIT abandons the request immediately; imem_req drops asynchronously.
- pc_mux_control=1 only when pc_write=1; otherwise it is 0.

Test Plan:
- Reset release, BOOT_CYCLES=4, imem_ready tied 1 -> imem_req first high in cycle 4. Then pc_write/if_id_write high every cycle, pc_mux_control=0, counters 0.
- Steady fetch, load_use_hazard pulsed 2 cycles -> pc_write, if_id_write, imem_req low for exactly 2 cycles; stall_count=2; fetch resumes next cycle.
- FETCH, branch_taken with target 16'h0040 -> same cycle: if_id_flush=1, pc_mux_control=1, pc_write=1, pc_target=16'h0040; flush_count=1.
- imem_ready low 3 cycles after request; branch_taken (target 16'h0100) in the 2nd wait cycle -> imem_req held 3 cycles. On the ready cycle: flush=1, pc_mux_control=1, pc_write=1, if_id_write=0, pc_target=16'h0100.
- branch_taken and load_use_hazard in the same FETCH cycle -> branch wins: flush=1, pc_write=1; stall_count unchanged.
- halt decoded -> HALTED next cycle, halted=1, all enables 0 for 20 cycles despite branch/ready activity. Reset pulse low -> back to BOOT, counters cleared.
